// File: rtl/mrp_tx_pkg.sv
// Types shared by the MRP TX NoC-out control FSM and its datapath.
// Flit mux select encodings and the control state encoding live here.
package mrp_tx_pkg;

  localparam int UDP_LENGTH_W   = 16;
  localparam int NOC_FLIT_BYTES = 64;

  typedef enum logic [1:0] {
    SEL_HDR_FLIT  = 2'd0,
    SEL_META_FLIT = 2'd1,
    SEL_DATA_FLIT = 2'd2
  } mrp_noc_out_flit_mux_sel;

  typedef enum logic [1:0] {
    READY = 2'd0,
    HDR   = 2'd1,
    META  = 2'd2,
    DATA  = 2'd3
  } mrp_noc_out_ctrl_state;

  // Number of payload flits a request of len bytes occupies on the NoC.
  function automatic int unsigned num_data_flits(input logic [UDP_LENGTH_W-1:0] len);
    return (int'(len) + NOC_FLIT_BYTES - 1) / NOC_FLIT_BYTES;
  endfunction

endpackage

// File: rtl/mrp_tx_noc_out_ctrl.sv
// Control FSM for the MRP TX NoC-out path: accepts one send request, then
// sequences header, metadata and payload flits onto noc0.
module mrp_tx_noc_out_ctrl
  import mrp_tx_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          mrp_mrp_tx_out_tx_meta_val,
  output logic                          mrp_tx_out_mrp_mrp_tx_meta_rdy,
  input  logic [UDP_LENGTH_W-1:0]       mrp_mrp_tx_out_tx_len,

  input  logic                          mrp_mrp_tx_out_tx_data_val,
  output logic                          mrp_tx_out_mrp_mrp_tx_data_rdy,

  output logic                          mrp_tx_out_noc0_vrtoc_val,
  input  logic                          noc0_vrtoc_mrp_tx_out_rdy,

  output mrp_noc_out_flit_mux_sel       ctrl_datap_flit_sel,
  output logic                          ctrl_datap_store_inputs,
  input  logic                          datap_ctrl_last_output
);

  mrp_noc_out_ctrl_state state_q, state_d;
  logic                  zero_len_q, zero_len_d;

  logic meta_acc;
  logic noc_hs;
  logic data_hs;

  assign meta_acc = (state_q == READY) & mrp_mrp_tx_out_tx_meta_val;
  assign noc_hs   = mrp_tx_out_noc0_vrtoc_val & noc0_vrtoc_mrp_tx_out_rdy;
  assign data_hs  = (state_q == DATA) & mrp_mrp_tx_out_tx_data_val
                    & noc0_vrtoc_mrp_tx_out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      zero_len_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      zero_len_q <= zero_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zero_len_d = zero_len_q;
    unique case (state_q)
      READY: begin
        if (meta_acc) begin
          zero_len_d = (mrp_mrp_tx_out_tx_len == '0);
          state_d    = HDR;
        end
      end
      HDR: begin
        if (noc_hs) state_d = META;
      end
      // A zero-length send ends after the metadata flit; no payload is pulled.
      META: begin
        if (noc_hs) state_d = zero_len_q ? READY : DATA;
      end
      DATA: begin
        if (data_hs && datap_ctrl_last_output) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_comb begin
    mrp_tx_out_mrp_mrp_tx_meta_rdy = 1'b0;
    mrp_tx_out_mrp_mrp_tx_data_rdy = 1'b0;
    mrp_tx_out_noc0_vrtoc_val      = 1'b0;
    ctrl_datap_flit_sel            = SEL_HDR_FLIT;
    ctrl_datap_store_inputs        = 1'b0;
    unique case (state_q)
      READY: begin
        mrp_tx_out_mrp_mrp_tx_meta_rdy = 1'b1;
        ctrl_datap_store_inputs        = mrp_mrp_tx_out_tx_meta_val;
      end
      HDR: begin
        ctrl_datap_flit_sel       = SEL_HDR_FLIT;
        mrp_tx_out_noc0_vrtoc_val = 1'b1;
      end
      META: begin
        ctrl_datap_flit_sel       = SEL_META_FLIT;
        mrp_tx_out_noc0_vrtoc_val = 1'b1;
      end
      // Payload is a straight passthrough: upstream valid to noc, noc ready back.
      DATA: begin
        ctrl_datap_flit_sel            = SEL_DATA_FLIT;
        mrp_tx_out_noc0_vrtoc_val      = mrp_mrp_tx_out_tx_data_val;
        mrp_tx_out_mrp_mrp_tx_data_rdy = noc0_vrtoc_mrp_tx_out_rdy;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_data_rdy_in_data: assert property (@(posedge clk) disable iff (rst)
    mrp_tx_out_mrp_mrp_tx_data_rdy |-> (state_q == DATA));

  a_data_sel_in_data: assert property (@(posedge clk) disable iff (rst)
    (mrp_tx_out_noc0_vrtoc_val && (ctrl_datap_flit_sel == SEL_DATA_FLIT))
      |-> (state_q == DATA));

  a_last_in_data: assert property (@(posedge clk) disable iff (rst)
    (datap_ctrl_last_output && mrp_tx_out_mrp_mrp_tx_data_rdy) |-> (state_q == DATA));
`endif

endmodule

// File: tb/tb_mrp_tx_noc_out_ctrl.sv
// Bench for mrp_tx_noc_out_ctrl: a cycle table from reset, then multi-cycle
// sequences checked against a flit-order scoreboard.
module tb_mrp_tx_noc_out_ctrl;
  import mrp_tx_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    meta_val;
  logic                    meta_rdy;
  logic [UDP_LENGTH_W-1:0] tx_len;
  logic                    data_val;
  logic                    data_rdy;
  logic                    noc_val;
  logic                    noc_rdy;
  mrp_noc_out_flit_mux_sel flit_sel;
  logic                    store_inputs;
  logic                    last;

  mrp_tx_noc_out_ctrl dut (
    .clk                            (clk),
    .rst                            (rst),
    .mrp_mrp_tx_out_tx_meta_val     (meta_val),
    .mrp_tx_out_mrp_mrp_tx_meta_rdy (meta_rdy),
    .mrp_mrp_tx_out_tx_len          (tx_len),
    .mrp_mrp_tx_out_tx_data_val     (data_val),
    .mrp_tx_out_mrp_mrp_tx_data_rdy (data_rdy),
    .mrp_tx_out_noc0_vrtoc_val      (noc_val),
    .noc0_vrtoc_mrp_tx_out_rdy      (noc_rdy),
    .ctrl_datap_flit_sel            (flit_sel),
    .ctrl_datap_store_inputs        (store_inputs),
    .datap_ctrl_last_output         (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Scoreboard: expected flit order of the packet in flight.
  mrp_noc_out_flit_mux_sel exp_q[$];
  int  rem     = 0;
  int  nxfer   = 0;
  logic dr_seen = 1'b0;

  logic o_mr, o_dr, o_nv, o_st;
  mrp_noc_out_flit_mux_sel o_sel;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs 1ns later.
  task automatic step(input logic mv, input logic [UDP_LENGTH_W-1:0] len,
                      input logic dv, input logic nr, input logic r);
    logic e_mr, e_dr, e_nv, e_st;
    mrp_noc_out_flit_mux_sel e_sel;
    int n;
    meta_val = mv;
    tx_len   = len;
    data_val = dv;
    noc_rdy  = nr;
    rst      = r;
    last     = dv && (rem == 1);
    #1;
    o_mr = meta_rdy; o_dr = data_rdy; o_nv = noc_val; o_st = store_inputs; o_sel = flit_sel;
    if (r) begin
      exp_q.delete();
      rem = 0;
    end else begin
      if (exp_q.size() == 0) begin
        e_mr = 1'b1; e_dr = 1'b0; e_nv = 1'b0; e_st = mv; e_sel = SEL_HDR_FLIT;
      end else begin
        e_mr = 1'b0; e_st = 1'b0; e_sel = exp_q[0];
        e_nv = (exp_q[0] == SEL_DATA_FLIT) ? dv : 1'b1;
        e_dr = (exp_q[0] == SEL_DATA_FLIT) ? nr : 1'b0;
      end
      chk("meta_rdy", int'(o_mr), int'(e_mr));
      chk("data_rdy", int'(o_dr), int'(e_dr));
      chk("noc_val",  int'(o_nv), int'(e_nv));
      chk("store_inputs", int'(o_st), int'(e_st));
      if (e_nv) chk("flit_sel", int'(o_sel), int'(e_sel));
      if (o_dr) dr_seen = 1'b1;
      if (e_nv && nr && exp_q.size() != 0) begin
        if (exp_q[0] == SEL_DATA_FLIT) begin
          rem--;
          nxfer++;
        end
        void'(exp_q.pop_front());
      end
      if (mv && e_mr) begin
        n = int'(num_data_flits(len));
        exp_q.push_back(SEL_HDR_FLIT);
        exp_q.push_back(SEL_META_FLIT);
        for (int i = 0; i < n; i++) exp_q.push_back(SEL_DATA_FLIT);
        rem = n;
      end
    end
    @(negedge clk);
  endtask

  // Accept one request, then drive it to completion with optional stalls and
  // a per-DATA-cycle data_val pattern. Optionally hold the next request.
  task automatic run_pkt(input logic [UDP_LENGTH_W-1:0] len, input int hdr_stall,
                         input int meta_stall, input logic [31:0] dv_pat,
                         input logic hold_mv, input logic [UDP_LENGTH_W-1:0] hold_len,
                         output int cyc, output int xfers);
    int hs, ms, di;
    logic nr, dv;
    nxfer = 0;
    step(1'b1, len, 1'b0, 1'b1, 1'b0);
    chk("accepted", exp_q.size(), 2 + int'(num_data_flits(len)));
    cyc = 0; hs = 0; ms = 0; di = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      nr = 1'b1;
      dv = 1'b1;
      if (exp_q[0] == SEL_HDR_FLIT && hs < hdr_stall) begin
        nr = 1'b0; hs++;
      end else if (exp_q[0] == SEL_META_FLIT && ms < meta_stall) begin
        nr = 1'b0; ms++;
      end
      if (exp_q[0] == SEL_DATA_FLIT) begin
        dv = (di < 32) ? dv_pat[di] : 1'b1;
        di++;
      end
      step(hold_mv, hold_len, dv, nr, 1'b0);
      cyc++;
    end
    if (exp_q.size() != 0) chk("pkt_timeout", cyc, -1);
    xfers = nxfer;
  endtask

  typedef struct {
    logic mv; logic [UDP_LENGTH_W-1:0] len; logic dv; logic nr;
    logic e_mr; logic e_dr; logic e_nv; mrp_noc_out_flit_mux_sel e_sel; logic e_st;
  } vec_t;

  vec_t vt[13];

  initial begin
    int cyc, xf;
    // mv len dv nr | meta_rdy data_rdy noc_val sel store
    vt[0]  = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SEL_HDR_FLIT,  1'b0};
    vt[1]  = '{1'b1, 16'd64, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SEL_HDR_FLIT,  1'b1};
    vt[2]  = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SEL_HDR_FLIT,  1'b0};
    vt[3]  = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, SEL_HDR_FLIT,  1'b0};
    vt[4]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_META_FLIT, 1'b0};
    vt[5]  = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, SEL_META_FLIT, 1'b0};
    vt[6]  = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, SEL_DATA_FLIT, 1'b0};
    vt[7]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_DATA_FLIT, 1'b0};
    vt[8]  = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, SEL_DATA_FLIT, 1'b0};
    vt[9]  = '{1'b1, 16'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEL_HDR_FLIT,  1'b1};
    vt[10] = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, SEL_HDR_FLIT,  1'b0};
    vt[11] = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, SEL_META_FLIT, 1'b0};
    vt[12] = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEL_HDR_FLIT,  1'b0};

    meta_val = 1'b0; tx_len = '0; data_val = 1'b0; noc_rdy = 1'b0; rst = 1'b1; last = 1'b0;
    @(negedge clk);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].mv, vt[i].len, vt[i].dv, vt[i].nr, 1'b0);
      chk($sformatf("vec%0d.meta_rdy", i), int'(o_mr), int'(vt[i].e_mr));
      chk($sformatf("vec%0d.data_rdy", i), int'(o_dr), int'(vt[i].e_dr));
      chk($sformatf("vec%0d.noc_val", i),  int'(o_nv), int'(vt[i].e_nv));
      chk($sformatf("vec%0d.flit_sel", i), int'(o_sel), int'(vt[i].e_sel));
      chk($sformatf("vec%0d.store", i),    int'(o_st), int'(vt[i].e_st));
    end

    // 100 bytes: hdr, meta, two data flits on consecutive cycles.
    run_pkt(16'd100, 0, 0, 32'hFFFF_FFFF, 1'b0, 16'd0, cyc, xf);
    chk("t1_cycles", cyc, 4);
    chk("t1_xfers", xf, 2);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("t1_meta_rdy_after", int'(o_mr), 1);

    // Zero length: two flits, data_rdy never raised despite data_val.
    dr_seen = 1'b0;
    run_pkt(16'd0, 0, 0, 32'hFFFF_FFFF, 1'b0, 16'd0, cyc, xf);
    chk("t2_cycles", cyc, 2);
    chk("t2_xfers", xf, 0);
    chk("t2_data_rdy_seen", int'(dr_seen), 0);

    // Stalls of 3 in HDR and 2 in META on a one-flit packet.
    run_pkt(16'd64, 3, 2, 32'hFFFF_FFFF, 1'b0, 16'd0, cyc, xf);
    chk("t3_cycles", cyc, 3 + 5);
    chk("t3_xfers", xf, 1);

    // Gapped data_val 1,0,0,1,1 on a 192-byte packet.
    run_pkt(16'd192, 0, 0, 32'h0000_0019, 1'b0, 16'd0, cyc, xf);
    chk("t4_cycles", cyc, 2 + 5);
    chk("t4_xfers", xf, 3);

    // Back-to-back with the second request held throughout the first.
    run_pkt(16'd64, 0, 0, 32'hFFFF_FFFF, 1'b1, 16'd128, cyc, xf);
    chk("t5a_cycles", cyc, 3);
    chk("t5a_xfers", xf, 1);
    run_pkt(16'd128, 0, 0, 32'hFFFF_FFFF, 1'b0, 16'd0, cyc, xf);
    chk("t5b_store_on_accept", int'(o_st), 0);
    chk("t5b_cycles", cyc, 4);
    chk("t5b_xfers", xf, 2);

    // Reset in the middle of a 256-byte packet's DATA phase.
    nxfer = 0;
    step(1'b1, 16'd256, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && nxfer < 2; i++) step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t6_in_data", int'(exp_q.size() != 0 && exp_q[0] == SEL_DATA_FLIT), 1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t6_rst_meta_rdy", int'(o_mr), 1);
    chk("t6_rst_noc_val",  int'(o_nv), 0);
    chk("t6_rst_data_rdy", int'(o_dr), 0);
    run_pkt(16'd64, 0, 0, 32'hFFFF_FFFF, 1'b0, 16'd0, cyc, xf);
    chk("t6_after_cycles", cyc, 3);
    chk("t6_after_xfers", xf, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mrp_tx_noc_out_ctrl.md
Name: mrp_tx_noc_out_ctrl

Overview:
Control FSM for the MRP TX NoC-out datapath. It accepts one UDP send request (metadata plus length) from the MRP TX engine and latches it into the datapath. It then drives onto noc0 a header flit, a UDP TX metadata flit, and the payload data flits through to the last one. Sits between the MRP TX engine and the noc0 router port of the MRP tile; owns the datapath's flit_sel and store_inputs controls.

Parameters:
none (flit contents and coordinates are handled in the datapath)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mrp_mrp_tx_out_tx_meta_val  in  1  send request valid (IPs/ports/len presented to datapath)
mrp_tx_out_mrp_mrp_tx_meta_rdy  out  1  request accepted
mrp_mrp_tx_out_tx_len  in  `UDP_LENGTH_W  payload bytes of request; used for zero-length detection
mrp_mrp_tx_out_tx_data_val  in  1  payload flit valid
mrp_tx_out_mrp_mrp_tx_data_rdy  out  1  payload flit consumed
mrp_tx_out_noc0_vrtoc_val  out  1  flit valid to noc0
noc0_vrtoc_mrp_tx_out_rdy  in  1  noc0 accepts flit
ctrl_datap_flit_sel  out  mrp_noc_out_flit_mux_sel  datapath output mux select
ctrl_datap_store_inputs  out  1  datapath latches request fields this cycle
datap_ctrl_last_output  in  1  current payload flit is last (datapath passthrough of data_last)

Behaviour:
- States: READY, HDR, META, DATA (enum mrp_noc_out_ctrl_state). Reset -> READY; zero_len_reg <= 0.
- Outputs are Moore/Mealy combinational from the state. Reset values are the READY values: meta_rdy = 1, all other valids/rdys = 0, store_inputs = 0, flit_sel = SEL_HDR_FLIT.
- READY:
  - meta_rdy = 1; store_inputs = meta_val.
  - On meta_val: zero_len_reg <= (tx_len == 0); next = HDR.
  - noc val = 0.
- HDR:
  - flit_sel = SEL_HDR_FLIT; noc val = 1; meta_rdy = 0.
  - On noc rdy -> META; else hold.
  - The header's msg_len comes from the latched length in the datapath (store_inputs is 0 here).
- META:
  - flit_sel = SEL_META_FLIT; noc val = 1.
  - On noc rdy: go to READY if zero_len_reg, else DATA.
- DATA:
  - flit_sel = SEL_DATA_FLIT.
  - noc val = data_val; data_rdy = noc rdy (pure passthrough, no buffering, zero added latency).
  - On data_val & noc rdy & datap_ctrl_last_output -> READY.
  - Non-last transfers stay in DATA.
  - data_rdy is never asserted outside DATA.
- Minimum packet occupancy: 3 cycles for a non-empty packet (HDR, META, one data flit) plus the accept cycle in READY. Back-to-back packets therefore have a 1-cycle READY bubble. This is required; no accept in DATA.
- Valid is never withdrawn while rdy is low in HDR/META.
  - In DATA, noc val follows upstream data_val.
  - Upstream obeys valid-hold, so that protocol is preserved.
- Zero-length request: the header carries msg_len = 1, and no data flits are consumed. Any data_val present is ignored until the next packet's DATA state.
- Simultaneous: meta_val in DATA/HDR/META is not accepted (meta_rdy = 0). The request fields must be held by upstream until acceptance.
- Reset mid-packet: next cycle the block is in READY with all outputs at reset values. The partial NoC message is abandoned; the system is reset as a whole.
- Assertions (sim only):
  - data_rdy only in DATA.
  - noc val & flit_sel == SEL_DATA_FLIT implies state == DATA.
  - datap_ctrl_last_output observed only in DATA.

Decomposition:
- mrp_tx_pkg (shared with datapath) holds:
  - mrp_noc_out_flit_mux_sel enum {SEL_HDR_FLIT, SEL_META_FLIT, SEL_DATA_FLIT};
  - new enum mrp_noc_out_ctrl_state.
- No sub-module; a single FSM with one state register plus zero_len_reg.
- A top-level mrp_tx_noc_out wrapper instantiates this block with mrp_tx_noc_out_datap.

Test Plan:
1. Single 100-byte request (64-byte flits), noc rdy = 1, data_val = 1 continuously -> noc sees hdr (msg_len 3), meta (data_length 100), data0, data1 (last) on 4 consecutive valid cycles; state returns to READY; meta_rdy high on cycle 5.
2. Zero-length request -> exactly 2 flits (hdr msg_len 1, meta data_length 0); data_rdy never asserted; back in READY after META.
3. noc rdy held low 3 cycles during HDR and 2 during META -> val stays 1 with flit_sel stable; flits are not duplicated; total cycle count is +5.
4. data_val gapped (1,0,0,1,1 last) for a 192-byte packet -> noc val mirrors data_val; exactly 3 data flits transferred; data_rdy == noc rdy every DATA cycle.
5. Two back-to-back requests (64 B then 128 B), meta_val held -> second is accepted only in the READY cycle after the first's last flit; second header msg_len 3 and src/dst fields match the second request.
6. Assert rst during DATA of a 256-byte packet -> next cycle: READY, noc val 0, data_rdy 0, meta_rdy 1; a new 64-byte request then completes normally with 3 flits.
